// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter with registered grant index and hold-time limit
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic [2:0] grant_idx_o,
    output logic       grant_valid_o,
    output logic       timeout_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] LIMIT = 8'(MAX_HOLD);
    state_t     state_q;
    logic [2:0] ptr_q, grant_idx_q, off, win;
    logic [7:0] hold_cnt_q;
    logic       grant_valid_q, timeout_q, hit, rel;
    // winner is the first requester at or after ptr, wrapping; release causes for the current owner
    always_comb begin
        off = 3'd0;
        for (int i = 7; i >= 0; i--) off = req_i[ptr_q + 3'(i)] ? 3'(i) : off;
        win = ptr_q + off;
        hit = (LIMIT != 8'd0) && (hold_cnt_q == LIMIT);
        rel = done_i || !req_i[grant_idx_q] || hit;
    end
    // arbitration FSM; timeout only when the limit is the sole surviving cause
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 3'd0;
            hold_cnt_q    <= 8'd0;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else if (state_q == IDLE) begin
            timeout_q <= 1'b0;
            if (req_i != 8'd0) begin
                state_q       <= GRANT;
                grant_idx_q   <= win;
                grant_valid_q <= 1'b1;
                hold_cnt_q    <= 8'd1;
            end
        end else if (rel) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            ptr_q         <= grant_idx_q + 3'd1;
            timeout_q     <= !done_i && req_i[grant_idx_q];
        end else begin
            hold_cnt_q <= hold_cnt_q + {7'd0, hold_cnt_q != 8'hFF};
            timeout_q  <= 1'b0;
        end
    end
    assign grant_idx_o   = grant_idx_q;
    assign grant_valid_o = grant_valid_q;
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: randomized and directed checks of three arbiter configurations against a reference model
module tb_rr_arbiter_8;
    logic       clk = 1'b0, rst = 1'b1, done = 1'b0;
    logic [7:0] req = 8'hFF;
    logic       gv [3];
    logic [2:0] gi [3];
    logic       to [3];
    int         errors = 0, checks = 0;
    int         mv [3], mi [3], mp [3], mc [3], mt [3];
    int         mh [3] = '{16, 4, 0};
    int         k, cnt, nto;

    rr_arbiter_8 #(.MAX_HOLD(16)) d16 (.clk(clk), .rst(rst), .req_i(req), .done_i(done),
        .grant_idx_o(gi[0]), .grant_valid_o(gv[0]), .timeout_o(to[0]));
    rr_arbiter_8 #(.MAX_HOLD(4)) d4 (.clk(clk), .rst(rst), .req_i(req), .done_i(done),
        .grant_idx_o(gi[1]), .grant_valid_o(gv[1]), .timeout_o(to[1]));
    rr_arbiter_8 #(.MAX_HOLD(0)) d0 (.clk(clk), .rst(rst), .req_i(req), .done_i(done),
        .grant_idx_o(gi[2]), .grant_valid_o(gv[2]), .timeout_o(to[2]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference behaviour applied at one rising edge, from the current inputs
    task automatic model_edge();
        for (int n = 0; n < 3; n++) begin
            if (rst) begin
                mv[n] = 0; mi[n] = 0; mp[n] = 0; mc[n] = 0; mt[n] = 0;
            end else if (mv[n] == 0) begin
                mt[n] = 0;
                if (req != 8'd0) begin
                    for (int j = 7; j >= 0; j--) if (req[(mp[n] + j) % 8]) mi[n] = (mp[n] + j) % 8;
                    mv[n] = 1;
                    mc[n] = 1;
                end
            end else if (done || !req[mi[n]] || (mh[n] != 0 && mc[n] == mh[n])) begin
                mt[n] = (!done && req[mi[n]]) ? 1 : 0;
                mv[n] = 0;
                mp[n] = (mi[n] + 1) % 8;
            end else begin
                mc[n] = (mc[n] < 255) ? mc[n] + 1 : 255;
                mt[n] = 0;
            end
        end
    endtask

    task automatic check_inst(input int n, input logic [2:0] p, input logic [7:0] hc);
        check($sformatf("valid%0d", n), gv[n], mv[n]);
        check($sformatf("idx%0d", n), gi[n], mi[n]);
        check($sformatf("timeout%0d", n), to[n], mt[n]);
        check($sformatf("ptr%0d", n), p, mp[n]);
        check($sformatf("hold%0d", n), hc, mc[n]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_inst(0, d16.ptr_q, d16.hold_cnt_q);
        check_inst(1, d4.ptr_q, d4.hold_cnt_q);
        check_inst(2, d0.ptr_q, d0.hold_cnt_q);
    endtask

    task automatic wait_valid(input int n, output int w);
        w = 0;
        while (gv[n] !== 1'b1 && w < 12) begin
            step();
            w++;
        end
        check("wait_valid", gv[n], 1);
    endtask

    task automatic grant_release(input logic [7:0] r, input int exp, output int w);
        req = r;
        wait_valid(0, w);
        check("grant_idx", gi[0], exp);
        done = 1'b1;
        step();
        done = 1'b0;
        check("released", gv[0], 0);
    endtask

    initial begin
        step();
        check("rst_valid", gv[0], 0);
        check("rst_idx", gi[0], 0);
        check("rst_timeout", to[0], 0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            grant_release(8'hFF, i % 8, k);
            check("rr_gap", k, 1);
        end
        grant_release(8'h20, 5, k);
        grant_release(8'h05, 0, k);
        grant_release(8'h05, 2, k);
        check("wrap_ptr", d16.ptr_q, 3);
        req = 8'h10;
        wait_valid(0, k);
        check("drop_idx", gi[0], 4);
        step();
        step();
        req = 8'h00;
        step();
        check("drop_valid", gv[0], 0);
        check("drop_timeout", to[0], 0);
        check("drop_ptr", d16.ptr_q, 5);
        req = 8'h08;
        wait_valid(1, k);
        cnt = 0;
        while (gv[1] && cnt < 20) begin
            cnt++;
            step();
        end
        check("to_len", cnt, 4);
        check("to_pulse", to[1], 1);
        step();
        check("to_pulse_end", to[1], 0);
        check("regrant_valid", gv[1], 1);
        check("regrant_idx", gi[1], 3);
        step();
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("done_wins_to", to[1], 0);
        check("done_wins_valid", gv[1], 0);
        req = 8'h01;
        nto = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (to[2]) nto++;
        end
        check("mh0_valid", gv[2], 1);
        check("mh0_hold", d0.hold_cnt_q, 255);
        check("mh0_timeouts", nto, 0);
        req = 8'hFF;
        wait_valid(0, k);
        rst = 1'b1;
        step();
        check("rst2_valid", gv[0], 0);
        check("rst2_idx", gi[0], 0);
        check("rst2_timeout", to[0], 0);
        step();
        rst = 1'b0;
        wait_valid(0, k);
        check("rst2_first", gi[0], 0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom & $urandom);
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter that produces a registered 3-bit grant index and a grant-valid flag. It sits directly upstream of the 3-to-8 decoder, which turns `grant_idx` into the one-hot grant bus gated by `grant_valid`. It holds each grant until the owner signals completion, drops its request, or exceeds a hold-time limit.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before a forced release. 0 disables the limit. Legal range 0..255.
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector. Bit i is requester i.
- `done`  in  1  owner finished. Sampled only while `grant_valid`=1.
- `grant_idx`  out  3  index of the current owner. Feeds the decoder `in`.
- `grant_valid`  out  1  `grant_idx` is a live grant.
- `timeout`  out  1  one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- Internal state:
  - FSM state: IDLE or GRANT.
  - `ptr[2:0]`: highest-priority index for the next arbitration.
  - `hold_cnt[7:0]`.
- Reset (`rst`=1 at an edge), regardless of state:
  - state=IDLE, `ptr`=0, `hold_cnt`=0.
  - `grant_idx`=0, `grant_valid`=0, `timeout`=0.
  - A grant in progress is dropped with no `timeout` pulse.
- IDLE:
  - If `req`=0, stay in IDLE and keep all outputs unchanged (except `grant_valid`=0).
  - Otherwise the winner is the first set bit of `req` scanning `ptr`, `ptr`+1, … modulo 8 (wrap 7→0).
  - Next edge: `grant_idx`=winner, `grant_valid`=1, `hold_cnt`=1, state=GRANT.
- GRANT: release is evaluated each cycle, in priority order:
  1. `done`=1.
  2. `req[grant_idx]`=0.
  3. `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD`. This is the only cause that pulses `timeout`=1 on the next cycle.
- On release at the next edge:
  - `grant_valid`=0, state=IDLE.
  - `ptr`=`grant_idx`+1 modulo 8 (7→0).
  - `grant_idx` keeps its value.
- With no release, `hold_cnt` increments, saturating at 255.
- When `done` and timeout coincide, the release counts as `done` and `timeout` stays 0.
- Requests arriving or dropping for non-owners during GRANT have no effect until the next IDLE cycle.
- `timeout` is 1 for exactly one cycle and 0 otherwise.

## Timing
- Grant latency: `req` sampled in IDLE at edge k → `grant_valid`=1 after edge k.
- Release latency: release condition at edge k → `grant_valid`=0 after edge k.
- Every release is followed by at least one IDLE cycle with `grant_valid`=0. Back-to-back grants are therefore spaced ≥1 dead cycle apart, so the downstream decoder never sees two owners without a gap.
- A single continuously requesting agent with `MAX_HOLD`=N is granted for N cycles, idle 1 cycle, then granted again.
- `grant_idx` changes only on the edge where `grant_valid` rises. It is stable throughout a grant and during the dead cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset check: assert `rst` for 2 cycles with `req`=8'hFF while a grant is active.
  - Required: `grant_valid`=0, `grant_idx`=0 and `timeout`=0 one edge after `rst`.
  - Required: after `rst` deasserts, the first grant goes to index 0.
- Round-robin order: hold `req`=8'hFF and pulse `done` one cycle after each grant.
  - Required grant sequence: 0,1,2,…,7,0, with exactly one dead cycle between grants.
- Wrap and skip: `ptr`=6 (after a grant to 5 is released) and `req`=8'b0000_0101.
  - Required: the grant goes to 0, then to 2 on the next arbitration.
  - Required: after the grant to 2 is released, `ptr`=3.
- Request drop: grant index 4, then clear `req[4]` on cycle 3 of the grant.
  - Required: `grant_valid`=0 on the next edge, `timeout`=0, `ptr`=5.
- Timeout: `MAX_HOLD`=4, `req`=8'h08 held, `done`=0.
  - Required: `grant_valid`=1 for exactly 4 cycles.
  - Required: `timeout`=1 for one cycle coincident with `grant_valid` falling.
  - Required: regrant to 3 after one dead cycle.
  - Repeat with `done`=1 on the 4th cycle: required `timeout` stays 0.
- `MAX_HOLD`=0: hold `req`=8'h01 for 300 cycles.
  - Required: a single continuous grant, `hold_cnt` saturates at 255, and no `timeout`.
